hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage processor. It sits beside the decode-stage bypass logic and decides, every cycle, whether each pipeline latch advances, holds, or is loaded with a bubble. It covers three cases: load-use stalls, multi-cycle multiply/divide sequencing, and branch/jump flushes. It also keeps a saturating stall-cycle counter and a multdiv timeout error flag.

## Interface
Parameters:
- MD_TIMEOUT, 40: max cycles to wait for multdiv_ready after md_start before aborting.
- CNT_W, 16: width of stall_count.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset as decided.
- fd_instruction  in  32  instruction in F/D latch (being decoded).
- de_instruction  in  32  instruction in D/X latch (executing).
- branch_taken  in  1  execute stage resolved a taken branch/jump/jr this cycle.
- multdiv_ready  in  1  multdiv unit result valid (single-cycle pulse).
- stall_pc  out  1  hold PC.
- stall_fd  out  1  hold F/D latch.
- stall_de  out  1  hold D/X latch.
- bubble_de  out  1  load nop (32'b0) into D/X latch next edge.
- bubble_em  out  1  load nop into X/M latch next edge.
- flush  out  1  load nop into F/D and D/X latches next edge.
- md_start  out  1  one-cycle start pulse to multdiv unit.
- md_error  out  1  sticky: a multdiv timed out.
- stall_count  out  CNT_W  saturating count of cycles with stall_pc high.

## Operation
- Decode fields are opcode [31:27], rd [26:22], rs [21:17], rt [16:12], and aluop [6:2].
- Sources read by fd_instruction:
  - opcode 00000: rs and rt.
  - 00111 (sw), 00010 (bne), 00110 (blt): rd and rs.
  - 00100 (jr): rd.
  - 00101 (addi), 01000 (lw): rs.
  - 10110 (bex): r30.
  - All others: none.
- Register 0 never causes a hazard.
- Load-use hazard: de opcode is 01000, de rd != 0, and de rd equals any fd source.
  - Effect: stall_pc = stall_fd = bubble_de = 1 for that cycle.
  - Combinational in IDLE. It clears naturally once the bubble reaches D/X.
- A multdiv op is de opcode 00000 with aluop 00110 (mul) or 00111 (div).
- States:
  - IDLE
    - A multdiv op in D/X with branch_taken = 0 moves to MD_WAIT. md_start is asserted that same cycle (combinational, IDLE only).
  - MD_WAIT
    - stall_pc = stall_fd = stall_de = bubble_em = 1. The timer increments each cycle.
    - multdiv_ready = 1 moves to MD_DONE.
    - Timer reaching MD_TIMEOUT-1 without ready moves to MD_DONE and sets md_error.
  - MD_DONE
    - No stalls for one cycle; the held multdiv op advances to X/M carrying the result. Then return to IDLE.
    - This prevents re-triggering on the same op.
- Priority, highest first:
  1. flush
  2. MD_WAIT stalls
  3. load-use stall
- branch_taken = 1 in any state:
  - flush = 1; all stall/bubble outputs are 0 that cycle.
  - In MD_WAIT it cannot occur, since X holds the multdiv op. If asserted there anyway, treat it as illegal: flush wins and the FSM still waits.
- stall_count increments when stall_pc = 1 and saturates at all-ones.
- md_error clears only on reset.

## Timing
- Reset values:
  - State IDLE, timer 0, stall_count 0, md_error 0.
  - Combinational outputs follow from IDLE: with no hazard present they are all 0.
- Load-use costs exactly 1 stall cycle.
- A multdiv op costs N+1 stall cycles when multdiv_ready arrives N cycles after md_start: md_start cycle plus N waits. The op advances in the MD_DONE cycle.
- Timeout: md_error rises at the edge ending the MD_TIMEOUT-th MD_WAIT cycle.
- multdiv_ready outside MD_WAIT is ignored.
- Reset mid-MD_WAIT returns to IDLE next edge. No md_start is re-issued unless a multdiv op is still in D/X after reset.

## Test plan
- **Load-use:** de = lw r5 (rd = 5); fd = add r1,r5,r2 (rs = 5) → stall_pc = stall_fd = bubble_de = 1 for exactly 1 cycle; stall_count = 1.
- **r0 / no hazard:** lw r0 followed by use of r0, and lw r5 followed by j → no stall outputs asserted.
- **mul sequencing:** de = mul, ready 5 cycles after md_start → md_start a single pulse; stalls high 6 cycles; MD_DONE 1 cycle; back to IDLE; stall_count = 6.
- **Timeout:** MD_TIMEOUT = 40, ready never asserted → md_error = 1 after 40 wait cycles; pipeline released; md_error stays 1 until reset.
- **Flush priority:** branch_taken = 1 concurrent with a load-use hazard → flush = 1, stall_pc = 0, bubble_de = 0.
- **Reset:** reset asserted in MD_WAIT cycle 3 → next cycle state IDLE, timer 0, md_error 0, stall_count 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      fd_instruction;
  logic [31:0]      de_instruction;
  logic             branch_taken;
  logic             multdiv_ready;
  logic             stall_pc;
  logic             stall_fd;
  logic             stall_de;
  logic             bubble_de;
  logic             bubble_em;
  logic             flush;
  logic             md_start;
  logic             md_error;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output fd_instruction, de_instruction, branch_taken, multdiv_ready,
    input  stall_pc, stall_fd, stall_de, bubble_de, bubble_em, flush,
           md_start, md_error, stall_count
  );

  modport slave (
    input  fd_instruction, de_instruction, branch_taken, multdiv_ready,
    output stall_pc, stall_fd, stall_de, bubble_de, bubble_em, flush,
           md_start, md_error, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, multdiv sequencing and flush control
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input logic          clock,
  input logic          reset,
  hazard_ctrl_if.slave bus
);
  localparam int TMR_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MD_WAIT, MD_DONE} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             md_error_q, md_error_d;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] de_op, de_rd, de_aluop;
  logic [4:0] src_a, src_b;
  logic       use_a, use_b;
  logic       load_use, md_op;
  logic       hold_md, stall_lu, branch;

  always_comb begin
    fd_op    = bus.fd_instruction[31:27];
    fd_rd    = bus.fd_instruction[26:22];
    fd_rs    = bus.fd_instruction[21:17];
    fd_rt    = bus.fd_instruction[16:12];
    de_op    = bus.de_instruction[31:27];
    de_rd    = bus.de_instruction[26:22];
    de_aluop = bus.de_instruction[6:2];
    src_a    = fd_rs;
    src_b    = fd_rt;
    use_a    = 1'b0;
    use_b    = 1'b0;
    case (fd_op)
      5'b00000: begin use_a = 1'b1; use_b = 1'b1; end
      5'b00111, 5'b00010, 5'b00110: begin
        src_a = fd_rd; src_b = fd_rs; use_a = 1'b1; use_b = 1'b1;
      end
      5'b00100: begin src_a = fd_rd; use_a = 1'b1; end
      5'b00101, 5'b01000: use_a = 1'b1;
      5'b10110: begin src_a = 5'd30; use_a = 1'b1; end
      default: ;
    endcase
    load_use = (de_op == 5'b01000) && (de_rd != 5'd0) &&
               ((use_a && (src_a == de_rd)) || (use_b && (src_b == de_rd)));
    md_op    = (de_op == 5'b00000) && ((de_aluop == 5'b00110) || (de_aluop == 5'b00111));
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    md_error_d = md_error_q;
    hold_md    = 1'b0;
    stall_lu   = 1'b0;
    branch     = bus.branch_taken;
    bus.md_start = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (md_op && !branch) begin
          // The start cycle is itself a stall so the op stays parked in D/X.
          state_d      = MD_WAIT;
          bus.md_start = 1'b1;
          hold_md      = 1'b1;
        end else if (load_use && !branch) begin
          stall_lu = 1'b1;
        end
      end
      MD_WAIT: begin
        hold_md = !branch;
        if (bus.multdiv_ready) begin
          state_d = MD_DONE;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d    = MD_DONE;
          timer_d    = '0;
          md_error_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      MD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bus.flush     = branch;
    bus.stall_pc  = hold_md || stall_lu;
    bus.stall_fd  = hold_md || stall_lu;
    bus.stall_de  = hold_md;
    bus.bubble_em = hold_md;
    bus.bubble_de = stall_lu;
    stall_count_d = stall_count_q;
    if (bus.stall_pc && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      stall_count_q <= '0;
      md_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stall_count_q <= stall_count_d;
      md_error_q    <= md_error_d;
    end
  end

  assign bus.md_error    = md_error_q;
  assign bus.stall_count = stall_count_q;
endmodule
